// File: rtl/box_slave_pkg.sv
// box_slave_pkg: shared types and constants for the AXI write-slave endpoint
package box_slave_pkg;
  localparam int PCOMPLETE_DATA = 64;
  localparam int AXI_LEN_W = 8;
  localparam int SLV_DATA_BYTES = 4;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic [1:0] {IDLE, DATA, RESP} slv_state_t;
endpackage

// File: rtl/box_slave_if.sv
// box_slave_if: AXI write address, data and response channels between master and slave
interface box_slave_if
  import box_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_BYTES = SLV_DATA_BYTES,
  parameter int ID_W = 4
);
  logic awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [AXI_LEN_W-1:0] awlen;
  logic [ID_W-1:0] awid;
  logic wvalid, wready, wlast;
  logic [8*DATA_BYTES-1:0] wdata;
  logic [DATA_BYTES-1:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic [ID_W-1:0] bid;
  modport master (
    output awvalid, awaddr, awlen, awid, wvalid, wdata, wstrb, wlast, bready,
    input awready, wready, bvalid, bresp, bid
  );
  modport slave (
    input awvalid, awaddr, awlen, awid, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/box_slave_wbuf.sv
// box_slave_wbuf: byte-addressed reassembly buffer with per-byte write enables and sync clear
module box_slave_wbuf #(
  parameter int DATA_BYTES = 4,
  parameter int BUF_BYTES = 64,
  localparam int IW = $clog2(BUF_BYTES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_i,
  input  logic                         we_i,
  input  logic [IW-1:0]                idx_i,
  input  logic [DATA_BYTES-1:0]        strb_i,
  input  logic [DATA_BYTES-1:0][7:0]   data_i,
  output logic [BUF_BYTES-1:0][7:0]    mem_o
);
  logic [BUF_BYTES-1:0][7:0] mem_q, mem_d;
  // clear wins; otherwise overlay strobed bytes, offsets wrap by truncation to IW bits
  always_comb begin
    mem_d = mem_q;
    if (clr_i) mem_d = '0;
    else if (we_i)
      for (int k = 0; k < DATA_BYTES; k++)
        if (strb_i[k]) mem_d[IW'(idx_i + IW'(k))] = data_i[k];
  end
  // buffer register, zeroed by reset
  always_ff @(posedge clk) mem_q <= !rst_n ? '0 : mem_d;
  assign mem_o = mem_q;
endmodule

// File: rtl/box_slave.sv
// box_slave: single-outstanding AXI write slave reassembling W beats into a byte buffer
module box_slave
  import box_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_BYTES = SLV_DATA_BYTES,
  parameter int ID_W = 4,
  parameter int BUF_BYTES = PCOMPLETE_DATA
) (
  input  logic                      clk,
  input  logic                      rst_n,
  box_slave_if.slave                bus,
  input  logic                      clr_buf,
  output logic                      burst_done,
  output logic [BUF_BYTES-1:0][7:0] ful_data
);
  localparam int IW = $clog2(BUF_BYTES);
  slv_state_t state_q, state_d;
  logic [IW-1:0] base_q, base_d;
  logic [AXI_LEN_W-1:0] len_q, len_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [8:0] cnt_q, cnt_d;
  resp_t resp_q, resp_d;
  logic w_hs, at_len, unused_addr;
  assign w_hs = bus.wvalid && bus.wready;
  assign at_len = cnt_q == 9'(len_q);
  assign unused_addr = ^bus.awaddr[ADDR_W-1:IW];
  assign bus.awready = state_q == IDLE;
  assign bus.wready = state_q == DATA;
  assign bus.bvalid = state_q == RESP;
  assign bus.bresp = resp_q;
  assign bus.bid = id_q;
  assign burst_done = state_q == RESP && bus.bready;
  // next state: capture AW in IDLE, count beats in DATA, wait for bready in RESP
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    id_d = id_q;
    cnt_d = cnt_q;
    resp_d = resp_q;
    if (state_q == IDLE && bus.awvalid) begin
      state_d = DATA;
      base_d = bus.awaddr[IW-1:0];
      len_d = bus.awlen;
      id_d = bus.awid;
      cnt_d = '0;
    end
    if (w_hs) begin
      cnt_d = cnt_q + 9'd1;
      if (bus.wlast || at_len) begin
        state_d = RESP;
        resp_d = bus.wlast && at_len ? OKAY : SLVERR;
      end
    end
    if (state_q == RESP && bus.bready) state_d = IDLE;
  end
  // state and burst context registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      resp_q <= OKAY;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      resp_q <= resp_d;
    end
  box_slave_wbuf #(.DATA_BYTES(DATA_BYTES), .BUF_BYTES(BUF_BYTES)) u_wbuf (
    .clk(clk),
    .rst_n(rst_n),
    .clr_i(clr_buf && state_q == IDLE),
    .we_i(w_hs),
    .idx_i(IW'(base_q + IW'(cnt_q * DATA_BYTES))),
    .strb_i(bus.wstrb),
    .data_i(bus.wdata),
    .mem_o(ful_data)
  );
endmodule

// File: tb/tb_box_slave.sv
// tb_box_slave: table-driven and randomized bench with a byte-array reference model
module tb_box_slave;
  import box_slave_pkg::*;
  logic clk = 0, rst_n = 0, clr_buf = 0, burst_done;
  logic [63:0][7:0] ful_data;
  int checks = 0, failures = 0;
  logic [7:0] mdl [64];
  logic [31:0] wd [300];
  logic [3:0] ws [300];
  typedef struct {
    logic [31:0] addr;
    int len;
    logic [3:0] id;
    int nsend;
    int lastpos;
    bit gap;
    int bdelay;
    bit clr_aw;
    bit clr_dat;
    bit rnd;
    logic [1:0] exp_resp;
  } vec_t;
  vec_t vt [9];
  always #5 clk = ~clk;
  box_slave_if #(.ADDR_W(32), .DATA_BYTES(4), .ID_W(4)) bus ();
  box_slave #(.ADDR_W(32), .DATA_BYTES(4), .ID_W(4), .BUF_BYTES(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_buf(clr_buf),
    .burst_done(burst_done), .ful_data(ful_data)
  );
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic chk_buf(input string nm);
    logic [511:0] e;
    for (int i = 0; i < 64; i++) e[i*8+:8] = mdl[i];
    checks++;
    if (ful_data !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, ful_data, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic mdl_clear();
    for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
  endtask
  task automatic mdl_beat(input logic [31:0] addr, input int i);
    for (int k = 0; k < 4; k++)
      if (ws[i][k]) mdl[(addr % 64 + i * 4 + k) % 64] = wd[i][k*8+:8];
  endtask
  task automatic fill(input bit rnd, input int n);
    for (int i = 0; i < n; i++) begin
      wd[i] = rnd ? $urandom : 32'h03020100 + 32'(i) * 32'h04040404;
      ws[i] = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  endtask
  task automatic run_burst(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int nsend, input int lastpos, input bit gap, input int bdelay,
                           input bit clr_aw, input bit clr_dat, input logic [1:0] exp_resp);
    int nacc;
    nacc = ((lastpos < 0 || lastpos > len) ? len : lastpos) + 1;
    chk("awready_idle", bus.awready, 1);
    bus.awvalid = 1;
    bus.awaddr = addr;
    bus.awlen = 8'(len);
    bus.awid = id;
    clr_buf = clr_aw;
    tick();
    bus.awvalid = 0;
    clr_buf = 0;
    if (clr_aw) mdl_clear();
    chk("aw_to_w", {bus.wready, bus.awready}, 2'b10);
    for (int i = 0; i < nsend; i++) begin
      if (gap && i > 0) begin
        bus.wvalid = 0;
        bus.wdata = $urandom;
        bus.wstrb = 4'hF;
        bus.wlast = 0;
        clr_buf = clr_dat;
        tick();
      end
      bus.wvalid = 1;
      bus.wdata = wd[i];
      bus.wstrb = ws[i];
      bus.wlast = i == lastpos;
      clr_buf = clr_dat;
      if (i < nacc) mdl_beat(addr, i);
      tick();
      if (i == nacc - 1) chk("w_to_b", bus.bvalid, 1);
    end
    bus.wvalid = 0;
    bus.wlast = 0;
    clr_buf = 0;
    chk("b_resp", {bus.bvalid, bus.bresp, bus.bid}, {1'b1, exp_resp, id});
    for (int c = 0; c < bdelay; c++) begin
      tick();
      chk("b_hold", {bus.bvalid, bus.awready, burst_done, bus.bresp, bus.bid},
          {1'b1, 1'b0, 1'b0, exp_resp, id});
    end
    bus.bready = 1;
    #1;
    chk("burst_done", burst_done, 1);
    tick();
    bus.bready = 0;
    #1;
    chk("post_b", {bus.awready, bus.wready, bus.bvalid, burst_done}, 4'b1000);
    chk_buf("buf");
  endtask
  initial begin
    logic [31:0] a;
    int len, lp, nacc;
    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awid = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    mdl_clear();
    vt[0] = '{32'd0,  3,   4'd5,  4,   3,  1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[1] = '{32'd16, 3,   4'd2,  3,   1,  1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b10};
    vt[2] = '{32'd32, 1,   4'd3,  3,   -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b10};
    vt[3] = '{32'd8,  3,   4'd9,  4,   3,  1'b1, 5, 1'b0, 1'b0, 1'b0, 2'b00};
    vt[4] = '{32'd40, 2,   4'd1,  3,   2,  1'b0, 0, 1'b0, 1'b1, 1'b1, 2'b00};
    vt[5] = '{32'd20, 0,   4'd15, 1,   0,  1'b0, 1, 1'b1, 1'b0, 1'b1, 2'b00};
    vt[6] = '{32'd4,  255, 4'd7,  256, 255, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00};
    vt[7] = '{32'd50, 5,   4'd6,  6,   5,  1'b1, 2, 1'b0, 1'b0, 1'b1, 2'b00};
    vt[8] = '{32'd7,  1,   4'd12, 2,   1,  1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("reset_hs", {bus.awready, bus.wready, bus.bvalid, burst_done}, 4'b1000);
    chk("reset_b", {bus.bresp, bus.bid}, 0);
    chk_buf("reset_buf");
    fill(0, vt[0].nsend);
    run_burst(vt[0].addr, vt[0].len, vt[0].id, vt[0].nsend, vt[0].lastpos, vt[0].gap,
              vt[0].bdelay, vt[0].clr_aw, vt[0].clr_dat, vt[0].exp_resp);
    for (int i = 0; i < 16; i++) chk($sformatf("basic_byte%0d", i), ful_data[i], i);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    wd[1] = 32'h11223344; ws[1] = 4'hF;
    run_burst(32'd60, 1, 4'd4, 2, 1, 1'b0, 0, 1'b0, 1'b0, 2'b00);
    chk("wrap_60", ful_data[60], 8'hDD);
    chk("wrap_61", ful_data[61], 8'h00);
    chk("wrap_62", ful_data[62], 8'hBB);
    chk("wrap_63", ful_data[63], 8'h00);
    chk("wrap_0_3", {ful_data[3], ful_data[2], ful_data[1], ful_data[0]}, 32'h11223344);
    for (int v = 1; v < 9; v++) begin
      fill(vt[v].rnd, vt[v].nsend);
      run_burst(vt[v].addr, vt[v].len, vt[v].id, vt[v].nsend, vt[v].lastpos, vt[v].gap,
                vt[v].bdelay, vt[v].clr_aw, vt[v].clr_dat, vt[v].exp_resp);
    end
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(0, 7);
      lp = $urandom_range(0, len + 1);
      if (lp == len + 1) lp = -1;
      nacc = (lp < 0 ? len : lp) + 1;
      a = $urandom;
      fill(1, nacc + 1);
      run_burst(a, len, 4'($urandom), nacc + int'($urandom_range(0, 1)), lp,
                1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                lp == len ? 2'b00 : 2'b10);
    end
    clr_buf = 1;
    tick();
    clr_buf = 0;
    mdl_clear();
    chk_buf("clr_idle");
    fill(1, 4);
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    bus.awvalid = 1; bus.awaddr = 32'd12; bus.awlen = 8'd3; bus.awid = 4'd8;
    tick();
    bus.awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      bus.wvalid = 1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = 0;
      mdl_beat(32'd12, i);
      tick();
    end
    chk_buf("mid_burst_buf");
    bus.wdata = wd[2];
    rst_n = 0;
    tick();
    rst_n = 1;
    bus.wvalid = 0;
    mdl_clear();
    chk("rst_mid_hs", {bus.awready, bus.wready, bus.bvalid, burst_done}, 4'b1000);
    chk_buf("rst_mid_buf");
    tick();
    chk("rst_mid_nob", {bus.awready, bus.bvalid}, 2'b10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
